rx_deser10: RTL and testbench
=============================

# rx_deser10

Serial-to-parallel receiver for the SERDES link; the receive end of the transmitter's 10-bit framed bit stream. Samples one line bit per rising edge of the shared bit clock, detects the start bit, shifts in LSB-first data and checks the stop bit. It presents each received word on a single-entry ready/valid holding register with framing and overrun status. A `bits_left` count mirrors the transmit-side "bits left in transit" counter.

## Interface
- `DATA_W`, 8: data bits per frame; frame length `FRAME_LEN` = `DATA_W`+2 (start+data+stop), +1 when parity is compiled in.
- `in`  input  1  bit clock, rising edge; one line bit sampled per edge.
- `ResetN`  input  1  reset, asynchronous, active-low.
- `sdata`  input  1  serial line, idle high, LSB first.
- `rx_data`  output  `DATA_W`  received word; reset 0.
- `rx_valid`  output  1  holding register full; reset 0.
- `rx_ready`  input  1  consumer accepts word when `rx_valid`&&`rx_ready` at an edge.
- `frame_err`  output  1  stop bit sampled low for the word in `rx_data`; qualified by `rx_valid`; reset 0.
- `parity_err`  output  1  parity mismatch for the word in `rx_data`; reset 0; tied 0 without parity.
- `overrun`  output  1  sticky: a completed frame was dropped; reset 0.
- `ovr_clr`  input  1  synchronous clear of `overrun`.
- `busy`  output  1  high in any state but IDLE; reset 0.
- `bits_left`  output  4  frame bits not yet sampled; `FRAME_LEN` in IDLE; reset `FRAME_LEN`.

## Operation
- FSM states: IDLE, DATA, PAR (parity build only), STOP.
- IDLE: `sdata`=0 at an edge -> DATA, `bits_left`←`FRAME_LEN`-1. `sdata`=1 -> stay in IDLE.
- DATA: shift `sdata` into bit position (`DATA_W`-1-remaining) so the first data bit lands in bit 0; decrement `bits_left` each edge. After the `DATA_W`th data bit, go to PAR or STOP.
- PAR: compare `sdata` against the even parity of the data bits; latch the result; -> STOP.
- STOP: sample `sdata`; `frame_err`←~`sdata`. Deliver the word and go to IDLE with `bits_left`←`FRAME_LEN`. A low stop bit does not hold off start detection: the next edge is evaluated in IDLE.
- Delivery:
  - If `rx_valid`=0, or the current word is being accepted this edge: load `rx_data`/`frame_err`/`parity_err` and set `rx_valid`=1.
  - Otherwise: drop the new word, keep the held word and its flags unchanged, and set `overrun`.
- Accept without new delivery: `rx_valid`←0. `rx_data` holds its last value.
- `overrun`: set on a drop; cleared by `ovr_clr`. A set and a clear on the same edge leave `overrun` set.
- `bits_left` arithmetic: 4-bit unsigned, never wraps; its minimum visible value is 1, in STOP.

## Timing
- Start bit sampled on edge 0. `rx_valid` is high after edge `FRAME_LEN`-1, i.e. registered on the stop-sample edge.
- Back-to-back frames: a start bit on the edge right after the stop edge is accepted. Sustained throughput is one word per `FRAME_LEN` edges with `rx_ready` held 1.
- Handshake: the word is consumed on the edge where `rx_valid`&&`rx_ready`. `rx_ready` may be high with `rx_valid` low; that has no effect.
- `ResetN` low at any time: asynchronously return to IDLE, discard the partial frame, set every output to its reset value. The first edge after release is evaluated in IDLE.

## Configuration
- `RX_PARITY_EN` defined: the PAR state exists, `FRAME_LEN`=`DATA_W`+3, and `parity_err` is driven (even parity over data bits).
- `RX_PARITY_EN` undefined: no PAR state, `FRAME_LEN`=`DATA_W`+2, and `parity_err` is constant 0.

## Structure
- Shared package `serdes_pkg` holds:
  - the FSM state enum (`RX_IDLE`, `RX_DATA`, `RX_PAR`, `RX_STOP`);
  - the `LINE_IDLE`=1 constant;
  - the `FRAME_LEN` derivation function, shared with the transmitter.
- One sub-module, `rx_bitcnt`: a loadable 4-bit down counter (load, decrement, reload-to-`FRAME_LEN`) driving `bits_left` and the FSM transitions.

## Test plan
- Basic word, no parity, `rx_ready`=1: send `sdata` 0,1,0,1,0,0,1,0,1,1 on 10 edges -> `rx_data`=0xA5, `rx_valid`=1 after edge 9, `frame_err`=0; `bits_left` steps 10,9,…,1,10.
- Bad stop: send 0x3C with stop=0 -> `rx_data`=0x3C, `frame_err`=1. A start on the next edge is received correctly.
- Overrun: `rx_ready`=0, send 0x11 then 0x22 -> `rx_data`=0x11 held, `overrun`=1. Then `ovr_clr` pulse -> `overrun`=0. Then `rx_ready`=1 -> `rx_valid`=0 next edge.
- Simultaneous accept and complete: `rx_ready` pulses on the 0x22 stop edge while 0x11 is held -> `rx_data`=0x22, `rx_valid` stays 1, `overrun`=0.
- Reset mid-frame: `ResetN` low after 4 data bits -> `busy`=0, `bits_left`=10, `rx_valid`=0 immediately. Next full frame 0x5A is received correctly.
- `RX_PARITY_EN`: 0x07 with parity bit 0 (three ones, so correct even parity is 1) -> `parity_err`=1, `bits_left` reset value 11.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared SERDES definitions: receive FSM states, line idle level and frame length.
// The frame length grows by one bit when RX_PARITY_EN is compiled in.
package serdes_pkg;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_DATA = 2'd1,
        RX_PAR  = 2'd2,
        RX_STOP = 2'd3
    } rx_state_e;

    localparam logic LINE_IDLE = 1'b1;

    // start + data + stop, plus the parity bit when present
    function automatic int frame_len(input int data_w, input bit par_en);
        return data_w + 2 + int'(par_en);
    endfunction

endpackage

// File: rtl/rx_deser10_if.sv
// Receiver-side bus: serial line in, word holding register out with ready/valid and status.
interface rx_deser10_if #(
    parameter int DATA_W = 8
);
    logic              sdata;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              frame_err;
    logic              parity_err;
    logic              overrun;
    logic              ovr_clr;
    logic              busy;
    logic [3:0]        bits_left;

    modport master (
        input  sdata, rx_ready, ovr_clr,
        output rx_data, rx_valid, frame_err, parity_err, overrun, busy, bits_left
    );

    modport slave (
        output sdata, rx_ready, ovr_clr,
        input  rx_data, rx_valid, frame_err, parity_err, overrun, busy, bits_left
    );
endinterface

// File: rtl/rx_deser10_bitcnt.sv
// Loadable 4-bit down counter of frame bits still to be sampled; saturates at 1.
module rx_bitcnt #(
    parameter logic [3:0] FRAME_LEN = 4'd10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    input  logic       reload,
    output logic [3:0] count
);
    logic [3:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (reload) begin
            count_d = FRAME_LEN;
        end else if (load) begin
            count_d = load_val;
        end else if (dec && (count_q > 4'd1)) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= FRAME_LEN;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/rx_deser10.sv
// 10-bit framed serial receiver (start, LSB-first data, stop) with a one-word holding register.
// Define RX_PARITY_EN to add an even-parity bit between the data and the stop bit.
module rx_deser10
    import serdes_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic         in,
    input  logic         ResetN,
    rx_deser10_if.master bus
);
`ifdef RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int         FRAME_LEN      = frame_len(DATA_W, PAR_EN);
    localparam logic [3:0] FL4            = 4'(FRAME_LEN);
    localparam logic [3:0] LAST_DATA_LEFT = 4'(FRAME_LEN - DATA_W);

    rx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
`ifdef RX_PARITY_EN
    logic              par_bad_q, par_bad_d;
    logic              parity_err_q, parity_err_d;
`endif

    logic       cnt_load, cnt_dec, cnt_reload;
    logic [3:0] bits_left;
    logic       frame_done, accept, drop;

    rx_bitcnt #(
        .FRAME_LEN (FL4)
    ) u_bitcnt (
        .clk      (in),
        .rst_n    (ResetN),
        .load     (cnt_load),
        .load_val (FL4 - 4'd1),
        .dec      (cnt_dec),
        .reload   (cnt_reload),
        .count    (bits_left)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_reload = 1'b0;
        frame_done = 1'b0;
`ifdef RX_PARITY_EN
        par_bad_d  = par_bad_q;
`endif
        case (state_q)
            RX_IDLE: begin
                if (bus.sdata != LINE_IDLE) begin
                    state_d  = RX_DATA;
                    cnt_load = 1'b1;
                end
            end
            RX_DATA: begin
                // shifting right lands the first (LSB) data bit in bit 0 after DATA_W bits
                shreg_d = {bus.sdata, shreg_q[DATA_W-1:1]};
                cnt_dec = 1'b1;
                if (bits_left == LAST_DATA_LEFT) begin
`ifdef RX_PARITY_EN
                    state_d = RX_PAR;
`else
                    state_d = RX_STOP;
`endif
                end
            end
`ifdef RX_PARITY_EN
            RX_PAR: begin
                par_bad_d = bus.sdata ^ (^shreg_q);
                cnt_dec   = 1'b1;
                state_d   = RX_STOP;
            end
`endif
            RX_STOP: begin
                cnt_reload = 1'b1;
                frame_done = 1'b1;
                state_d    = RX_IDLE;
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    always_comb begin
        accept      = rx_valid_q & bus.rx_ready;
        drop        = 1'b0;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = frame_err_q;
`ifdef RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        if (frame_done) begin
            if (!rx_valid_q || accept) begin
                rx_data_d   = shreg_q;
                rx_valid_d  = 1'b1;
                frame_err_d = ~bus.sdata;
`ifdef RX_PARITY_EN
                parity_err_d = par_bad_q;
`endif
            end else begin
                drop = 1'b1;
            end
        end else if (accept) begin
            rx_valid_d = 1'b0;
        end

        // a drop on the same edge as a clear wins
        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (bus.ovr_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge in or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= RX_IDLE;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef RX_PARITY_EN
    always_ff @(posedge in or negedge ResetN) begin
        if (!ResetN) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = (state_q != RX_IDLE);
    assign bus.bits_left = bits_left;
endmodule

// File: tb/tb_rx_deser10.sv
// Directed bench for rx_deser10: delivered words are queued when sent and checked on handshake.
module tb_rx_deser10;
`ifdef RX_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    logic clk_in   = 1'b0;
    logic reset_n  = 1'b1;
    int   errors   = 0;
    int   checks   = 0;
    logic [9:0] sb[$];

    rx_deser10_if #(.DATA_W(8)) bus ();

    rx_deser10 #(.DATA_W(8)) dut (
        .in     (clk_in),
        .ResetN (reset_n),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // scoreboard side: a word leaves the holding register on the next edge
    always @(negedge clk_in) begin
        if (reset_n && bus.rx_valid && bus.rx_ready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                chk("sb_word", {22'd0, bus.parity_err, bus.frame_err, bus.rx_data}, {22'd0, sb.pop_front()});
            end
        end
    end

    task automatic chk_edge(input int k, input bit en);
        logic [3:0] exp_bl;
        if (en) begin
            exp_bl = (k == FL - 1) ? 4'(FL) : 4'(FL - 1 - k);
            chk("bits_left_step", {28'd0, bus.bits_left}, {28'd0, exp_bl});
            chk("busy_step", {31'd0, bus.busy}, (k == FL - 1) ? 32'd0 : 32'd1);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit,
                              input bit push, input bit rdy_pulse, input bit chk_cnt);
        logic exp_perr;
        int   k;
`ifdef RX_PARITY_EN
        exp_perr = par_bit ^ (^d);
`else
        exp_perr = 1'b0;
`endif
        if (push) sb.push_back({exp_perr, ~stop_bit, d});
        k = 0;
        bus.sdata = 1'b0;
        tick();
        chk_edge(k, chk_cnt);
        for (int i = 0; i < 8; i++) begin
            bus.sdata = d[i];
            tick();
            k++;
            chk_edge(k, chk_cnt);
        end
`ifdef RX_PARITY_EN
        bus.sdata = par_bit;
        tick();
        k++;
        chk_edge(k, chk_cnt);
`endif
        if (rdy_pulse) bus.rx_ready = 1'b1;
        bus.sdata = stop_bit;
        tick();
        k++;
        chk_edge(k, chk_cnt);
        if (rdy_pulse) bus.rx_ready = 1'b0;
        bus.sdata = 1'b1;
    endtask

    initial begin
        bus.sdata    = 1'b1;
        bus.rx_ready = 1'b0;
        bus.ovr_clr  = 1'b0;

        // reset values
        #2 reset_n = 1'b0;
        #1;
        chk("rst_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("rst_data", {24'd0, bus.rx_data}, 32'd0);
        chk("rst_ferr", {31'd0, bus.frame_err}, 32'd0);
        chk("rst_perr", {31'd0, bus.parity_err}, 32'd0);
        chk("rst_ovr", {31'd0, bus.overrun}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_bits_left", {28'd0, bus.bits_left}, 32'(FL));
        tick();
        tick();
        #2 reset_n = 1'b1;
        tick();

        // basic word 0xA5 with consumer ready
        bus.rx_ready = 1'b1;
        chk("idle_bits_left", {28'd0, bus.bits_left}, 32'(FL));
        send_frame(8'hA5, 1'b1, ^8'hA5, 1'b1, 1'b0, 1'b1);
        chk("a5_valid", {31'd0, bus.rx_valid}, 32'd1);
        chk("a5_data", {24'd0, bus.rx_data}, 32'hA5);
        chk("a5_ferr", {31'd0, bus.frame_err}, 32'd0);
        tick();
        chk("a5_consumed", {31'd0, bus.rx_valid}, 32'd0);

        // bad stop bit, then a start on the very next edge
        send_frame(8'h3C, 1'b0, ^8'h3C, 1'b1, 1'b0, 1'b0);
        chk("3c_data", {24'd0, bus.rx_data}, 32'h3C);
        chk("3c_ferr", {31'd0, bus.frame_err}, 32'd1);
        send_frame(8'hC3, 1'b1, ^8'hC3, 1'b1, 1'b0, 1'b1);
        chk("c3_data", {24'd0, bus.rx_data}, 32'hC3);
        chk("c3_ferr", {31'd0, bus.frame_err}, 32'd0);
        tick();
        bus.rx_ready = 1'b0;

        // overrun: second word dropped while the first is held
        send_frame(8'h11, 1'b1, ^8'h11, 1'b1, 1'b0, 1'b0);
        chk("ovr_pre", {31'd0, bus.overrun}, 32'd0);
        send_frame(8'h22, 1'b1, ^8'h22, 1'b0, 1'b0, 1'b0);
        chk("ovr_held_data", {24'd0, bus.rx_data}, 32'h11);
        chk("ovr_held_valid", {31'd0, bus.rx_valid}, 32'd1);
        chk("ovr_set", {31'd0, bus.overrun}, 32'd1);
        tick();
        chk("ovr_sticky", {31'd0, bus.overrun}, 32'd1);
        bus.ovr_clr = 1'b1;
        tick();
        bus.ovr_clr = 1'b0;
        chk("ovr_cleared", {31'd0, bus.overrun}, 32'd0);
        chk("ovr_clr_valid", {31'd0, bus.rx_valid}, 32'd1);
        bus.rx_ready = 1'b1;
        tick();
        chk("ovr_drain_valid", {31'd0, bus.rx_valid}, 32'd0);
        bus.rx_ready = 1'b0;

        // accept on the same edge a new word completes
        send_frame(8'h11, 1'b1, ^8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, ^8'h22, 1'b1, 1'b1, 1'b0);
        chk("sim_data", {24'd0, bus.rx_data}, 32'h22);
        chk("sim_valid", {31'd0, bus.rx_valid}, 32'd1);
        chk("sim_ovr", {31'd0, bus.overrun}, 32'd0);
        bus.rx_ready = 1'b1;
        tick();
        chk("sim_drain_valid", {31'd0, bus.rx_valid}, 32'd0);
        bus.rx_ready = 1'b0;

        // reset in mid-frame with a word held
        send_frame(8'h77, 1'b1, ^8'h77, 1'b0, 1'b0, 1'b0);
        chk("mid_pre_valid", {31'd0, bus.rx_valid}, 32'd1);
        bus.sdata = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.sdata = 1'b1;
            tick();
        end
        chk("mid_busy_pre", {31'd0, bus.busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_bits_left", {28'd0, bus.bits_left}, 32'(FL));
        chk("mid_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("mid_data", {24'd0, bus.rx_data}, 32'd0);
        bus.sdata = 1'b1;
        #3 reset_n = 1'b1;
        tick();
        bus.rx_ready = 1'b1;
        send_frame(8'h5A, 1'b1, ^8'h5A, 1'b1, 1'b0, 1'b1);
        chk("5a_data", {24'd0, bus.rx_data}, 32'h5A);
        chk("5a_ferr", {31'd0, bus.frame_err}, 32'd0);
        tick();

`ifdef RX_PARITY_EN
        // wrong parity bit: three ones need a 1 for even parity
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("par_err", {31'd0, bus.parity_err}, 32'd1);
        chk("par_data", {24'd0, bus.rx_data}, 32'h07);
        tick();
        chk("par_bits_left", {28'd0, bus.bits_left}, 32'd11);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("par_ok", {31'd0, bus.parity_err}, 32'd0);
        tick();
`endif

        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
